// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access controller between the EX->MEM and MEM->WB pipeline
// registers. A load or store seen in IDLE is latched and turned into a
// req/ready handshake with a variable-latency data memory. The upstream
// pipeline is frozen while the access is outstanding. A single completed
// result, including any load data, is then shown to MEM->WB for one cycle.
// Non-memory instructions pass straight through combinationally.
//
// Parameters
//   WORD_LEN          data / address width
//   REG_FILE_ADDR_LEN destination register index width
//   MAX_WAIT          BUSY cycles without mem_ready before a timeout (>= 1)
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   WB_EN_IN, MEM_R_EN_IN,
//   MEM_W_EN_IN, destIn,
//   ALUResIn, STValIn            instruction fields from EX->MEM
//   WB_EN, MEM_R_EN, dest,
//   ALURes, memReadVal           result fields to MEM->WB
//   freeze                       hold IF/ID/EX and the EX->MEM register
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    request side of the memory handshake
//   mem_rdata, mem_ready         response side of the memory handshake
//   mem_err                      sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned WORD_LEN          = 32,
  parameter int unsigned REG_FILE_ADDR_LEN = 4,
  parameter int unsigned MAX_WAIT          = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WB_EN_IN,
  input  logic                         MEM_R_EN_IN,
  input  logic                         MEM_W_EN_IN,
  input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
  input  logic [WORD_LEN-1:0]          ALUResIn,
  input  logic [WORD_LEN-1:0]          STValIn,
  output logic                         WB_EN,
  output logic                         MEM_R_EN,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic [WORD_LEN-1:0]          ALURes,
  output logic [WORD_LEN-1:0]          memReadVal,
  output logic                         freeze,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [WORD_LEN-1:0]          mem_addr,
  output logic [WORD_LEN-1:0]          mem_wdata,
  input  logic [WORD_LEN-1:0]          mem_rdata,
  input  logic                         mem_ready,
  output logic                         mem_err
);

  localparam int unsigned           CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state_q;
  logic                           wbEn_q;
  logic                           memREn_q;
  logic                           isWrite_q;
  logic [REG_FILE_ADDR_LEN-1:0]   dest_q;
  logic [WORD_LEN-1:0]            aluRes_q;
  logic [WORD_LEN-1:0]            stVal_q;
  logic [WORD_LEN-1:0]            rdata_q;
  logic [CNT_W-1:0]               waitCnt_q;
  logic                           memErr_q;

  logic                           accessReq;
  logic [CNT_W-1:0]               waitCnt_d;

  // A read wins when both enables are set, so a write is only a pure store.
  assign accessReq = MEM_R_EN_IN | MEM_W_EN_IN;

  // The counter only ever counts up to MAX_WAIT before leaving BUSY, so this
  // increment cannot wrap.
  assign waitCnt_d = waitCnt_q + CNT_W'(1);

  // Whole access FSM: detection in IDLE, handshake and timeout in BUSY, and a
  // one-cycle result presentation in DONE. DONE ignores the inputs, because
  // the instruction that caused the access is still held there until freeze
  // drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wbEn_q    <= 1'b0;
      memREn_q  <= 1'b0;
      isWrite_q <= 1'b0;
      dest_q    <= '0;
      aluRes_q  <= '0;
      stVal_q   <= '0;
      rdata_q   <= '0;
      waitCnt_q <= '0;
      memErr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accessReq) begin
            wbEn_q    <= WB_EN_IN;
            memREn_q  <= MEM_R_EN_IN;
            isWrite_q <= MEM_W_EN_IN & ~MEM_R_EN_IN;
            dest_q    <= destIn;
            aluRes_q  <= ALUResIn;
            stVal_q   <= STValIn;
            waitCnt_q <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          // mem_ready is checked first so that a response in the last allowed
          // cycle still counts as a success.
          if (mem_ready) begin
            rdata_q <= isWrite_q ? '0 : mem_rdata;
            state_q <= DONE;
          end else if (waitCnt_d == MAX_CNT) begin
            waitCnt_q <= waitCnt_d;
            rdata_q   <= '0;
            memErr_q  <= 1'b1;
            state_q   <= DONE;
          end else begin
            waitCnt_q <= waitCnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output mux. These outputs are Moore functions of the state, except in
  // IDLE, where a non-memory instruction passes through and a memory
  // instruction raises freeze in the same cycle. While reset is asserted the
  // stage shows a bubble, so no partial result can escape.
  always_comb begin
    WB_EN      = 1'b0;
    MEM_R_EN   = 1'b0;
    dest       = '0;
    ALURes     = '0;
    memReadVal = '0;
    freeze     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (accessReq) begin
            freeze = 1'b1;
          end else begin
            WB_EN    = WB_EN_IN;
            MEM_R_EN = MEM_R_EN_IN;
            dest     = destIn;
            ALURes   = ALUResIn;
          end
        end
        BUSY: begin
          freeze  = 1'b1;
          mem_req = 1'b1;
          mem_we  = isWrite_q;
        end
        DONE: begin
          WB_EN      = wbEn_q;
          MEM_R_EN   = memREn_q;
          dest       = dest_q;
          ALURes     = aluRes_q;
          memReadVal = rdata_q;
        end
        default: begin
          freeze = 1'b0;
        end
      endcase
    end
  end

  // Address and write data come straight from the latches. They therefore
  // stay stable for the whole BUSY state.
  assign mem_addr  = aluRes_q;
  assign mem_wdata = stVal_q;
  assign mem_err   = memErr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Cycle-by-cycle directed vectors for mem_access_unit with MAX_WAIT = 4.
// Each table row holds the inputs for one clock cycle and the outputs
// expected during that cycle. The rows walk through these cases:
//   - pass-through
//   - a 3-cycle load
//   - a store
//   - a read/write collision that completes in the last allowed cycle
//   - a timeout
//   - a good access after the timeout
// A hand-written sequence then covers reset asserted in the middle of an
// access.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
  logic [3:0]  destIn;
  logic [31:0] ALUResIn, STValIn;
  logic        WB_EN, MEM_R_EN;
  logic [3:0]  dest;
  logic [31:0] ALURes, memReadVal;
  logic        freeze, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, mem_err;

  int checks;
  int failures;

  typedef struct {
    logic        wbIn;
    logic        mrIn;
    logic        mwIn;
    logic [3:0]  destIn;
    logic [31:0] aluIn;
    logic [31:0] stvIn;
    logic        rdy;
    logic [31:0] rdata;
    logic        eWb;
    logic        eMr;
    logic [3:0]  eDest;
    logic [31:0] eAlu;
    logic [31:0] eMrv;
    logic        eFrz;
    logic        eReq;
    logic        eWe;
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    logic        eErr;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];

  mem_access_unit #(
    .WORD_LEN(32),
    .REG_FILE_ADDR_LEN(4),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .WB_EN_IN(WB_EN_IN),
    .MEM_R_EN_IN(MEM_R_EN_IN),
    .MEM_W_EN_IN(MEM_W_EN_IN),
    .destIn(destIn),
    .ALUResIn(ALUResIn),
    .STValIn(STValIn),
    .WB_EN(WB_EN),
    .MEM_R_EN(MEM_R_EN),
    .dest(dest),
    .ALURes(ALURes),
    .memReadVal(memReadVal),
    .freeze(freeze),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_err(mem_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input vec_t v);
    WB_EN_IN    = v.wbIn;
    MEM_R_EN_IN = v.mrIn;
    MEM_W_EN_IN = v.mwIn;
    destIn      = v.destIn;
    ALUResIn    = v.aluIn;
    STValIn     = v.stvIn;
    mem_ready   = v.rdy;
    mem_rdata   = v.rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Loads a non-memory (NOP-like) instruction onto the inputs.
  task automatic driveNop();
    WB_EN_IN    = 1'b0;
    MEM_R_EN_IN = 1'b0;
    MEM_W_EN_IN = 1'b0;
    destIn      = 4'd0;
    ALUResIn    = 32'h0;
    STValIn     = 32'h0;
    mem_ready   = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Row fields, in order:
    //   inputs:   wbIn, mrIn, mwIn, destIn, aluIn, stvIn, rdy, rdata
    //   expected: WB_EN, MEM_R_EN, dest, ALURes, memReadVal, freeze,
    //             mem_req, mem_we, mem_addr, mem_wdata, mem_err
    // pass-through
    vecs[0]  = '{1'b1,1'b0,1'b0,4'd5,32'h1234,32'h0,1'b0,32'h0,   1'b1,1'b0,4'd5,32'h1234,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0};
    // load, ready on the 3rd BUSY cycle
    vecs[1]  = '{1'b1,1'b1,1'b0,4'd3,32'h40,32'h0,1'b0,32'h0,     1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b0,4'd3,32'h40,32'h0,1'b0,32'h0,     1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h40,32'h0,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,4'd3,32'h40,32'h0,1'b0,32'h0,     1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h40,32'h0,1'b0};
    vecs[4]  = '{1'b1,1'b1,1'b0,4'd3,32'h40,32'h0,1'b1,32'hDEADBEEF, 1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h40,32'h0,1'b0};
    vecs[5]  = '{1'b1,1'b1,1'b0,4'd3,32'h40,32'h0,1'b0,32'h0,     1'b1,1'b1,4'd3,32'h40,32'hDEADBEEF,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0};
    // back in IDLE: no second request; a stray mem_ready is ignored
    vecs[6]  = '{1'b0,1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,32'h5555,   1'b0,1'b0,4'd0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0};
    // store, ready on the 1st BUSY cycle; returned data must not be captured
    vecs[7]  = '{1'b0,1'b0,1'b1,4'd0,32'h80,32'hA5,1'b0,32'h0,    1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1,4'd0,32'h80,32'hA5,1'b1,32'h1111, 1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b1,32'h80,32'hA5,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1,4'd0,32'h80,32'hA5,1'b0,32'h0,    1'b0,1'b0,4'd0,32'h80,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0};
    // read+write collision: treated as a read, ready in the 4th (last) BUSY cycle
    vecs[10] = '{1'b1,1'b1,1'b1,4'd7,32'h100,32'h77,1'b0,32'h0,   1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b1,4'd7,32'h100,32'h77,1'b0,32'h0,   1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h100,32'h77,1'b0};
    vecs[12] = '{1'b1,1'b1,1'b1,4'd7,32'h100,32'h77,1'b0,32'h0,   1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h100,32'h77,1'b0};
    vecs[13] = '{1'b1,1'b1,1'b1,4'd7,32'h100,32'h77,1'b0,32'h0,   1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h100,32'h77,1'b0};
    vecs[14] = '{1'b1,1'b1,1'b1,4'd7,32'h100,32'h77,1'b1,32'hCAFEF00D, 1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h100,32'h77,1'b0};
    vecs[15] = '{1'b1,1'b1,1'b1,4'd7,32'h100,32'h77,1'b0,32'h0,   1'b1,1'b1,4'd7,32'h100,32'hCAFEF00D,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0};
    // timeout: never ready, DONE after 4 BUSY cycles
    vecs[16] = '{1'b1,1'b1,1'b0,4'd9,32'h200,32'h0,1'b0,32'h0,    1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0};
    vecs[17] = '{1'b1,1'b1,1'b0,4'd9,32'h200,32'h0,1'b0,32'h0,    1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h200,32'h0,1'b0};
    vecs[18] = '{1'b1,1'b1,1'b0,4'd9,32'h200,32'h0,1'b0,32'h0,    1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h200,32'h0,1'b0};
    vecs[19] = '{1'b1,1'b1,1'b0,4'd9,32'h200,32'h0,1'b0,32'h0,    1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h200,32'h0,1'b0};
    vecs[20] = '{1'b1,1'b1,1'b0,4'd9,32'h200,32'h0,1'b0,32'h0,    1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h200,32'h0,1'b0};
    vecs[21] = '{1'b1,1'b1,1'b0,4'd9,32'h200,32'h0,1'b0,32'h0,    1'b1,1'b1,4'd9,32'h200,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1};
    // good load afterwards: mem_err stays set
    vecs[22] = '{1'b1,1'b1,1'b0,4'd2,32'h44,32'h0,1'b0,32'h0,     1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b1};
    vecs[23] = '{1'b1,1'b1,1'b0,4'd2,32'h44,32'h0,1'b1,32'h12345678, 1'b0,1'b0,4'd0,32'h0,32'h0,1'b1,1'b1,1'b0,32'h44,32'h0,1'b1};
    vecs[24] = '{1'b1,1'b1,1'b0,4'd2,32'h44,32'h0,1'b0,32'h0,     1'b1,1'b1,4'd2,32'h44,32'h12345678,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1};
    vecs[25] = '{1'b0,1'b0,1'b0,4'd0,32'h0,32'h0,1'b0,32'h0,      1'b0,1'b0,4'd0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1};

    // Reset state
    rst = 1'b0;
    driveNop();
    WB_EN_IN = 1'b1;
    #12;
    checkOutput("reset.mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("reset.freeze", {31'b0, freeze}, 32'h0);
    checkOutput("reset.WB_EN", {31'b0, WB_EN}, 32'h0);
    checkOutput("reset.mem_err", {31'b0, mem_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    driveNop();
    @(posedge clk);
    #1;

    // Table-driven cycles: inputs are driven just after the rising edge and
    // outputs are sampled on the falling edge.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.WB_EN", i), {31'b0, WB_EN}, {31'b0, vecs[i].eWb});
      checkOutput($sformatf("vec%0d.MEM_R_EN", i), {31'b0, MEM_R_EN}, {31'b0, vecs[i].eMr});
      checkOutput($sformatf("vec%0d.dest", i), {28'b0, dest}, {28'b0, vecs[i].eDest});
      checkOutput($sformatf("vec%0d.ALURes", i), ALURes, vecs[i].eAlu);
      checkOutput($sformatf("vec%0d.memReadVal", i), memReadVal, vecs[i].eMrv);
      checkOutput($sformatf("vec%0d.freeze", i), {31'b0, freeze}, {31'b0, vecs[i].eFrz});
      checkOutput($sformatf("vec%0d.mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].eReq});
      checkOutput($sformatf("vec%0d.mem_err", i), {31'b0, mem_err}, {31'b0, vecs[i].eErr});
      if (vecs[i].eReq) begin
        checkOutput($sformatf("vec%0d.mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].eWe});
        checkOutput($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].eAddr);
        checkOutput($sformatf("vec%0d.mem_wdata", i), mem_wdata, vecs[i].eWdata);
      end
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of BUSY
    WB_EN_IN    = 1'b1;
    MEM_R_EN_IN = 1'b1;
    destIn      = 4'd6;
    ALUResIn    = 32'h300;
    @(negedge clk);
    checkOutput("midrst.detect_freeze", {31'b0, freeze}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midrst.busy_req", {31'b0, mem_req}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst.mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("midrst.freeze", {31'b0, freeze}, 32'h0);
    checkOutput("midrst.WB_EN", {31'b0, WB_EN}, 32'h0);
    checkOutput("midrst.mem_err", {31'b0, mem_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    // Back in IDLE: the held load is freshly detected, with no request yet
    checkOutput("midrst.idle_req", {31'b0, mem_req}, 32'h0);
    checkOutput("midrst.idle_freeze", {31'b0, freeze}, 32'h1);
    driveNop();
    #1;
    checkOutput("midrst.nop_freeze", {31'b0, freeze}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midrst.after_req", {31'b0, mem_req}, 32'h0);
    checkOutput("midrst.after_memReadVal", memReadVal, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller between the EX→MEM pipeline register and the MEM→WB pipeline register. Turns load/store requests into a req/ready handshake with a variable-latency data memory. Freezes the upstream pipeline while an access is outstanding, then presents one completed result, with load data, to MEM→WB. Non-memory instructions pass straight through with no added latency.

## Interface
- WORD_LEN, 32, data and address width
- REG_FILE_ADDR_LEN, 4, destination register index width
- MAX_WAIT, 15, max BUSY cycles without mem_ready before timeout (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  in  1 each  control from EX→MEM
- destIn  in  REG_FILE_ADDR_LEN  destination register
- ALUResIn  in  WORD_LEN  ALU result / memory address
- STValIn  in  WORD_LEN  store data
- WB_EN, MEM_R_EN  out  1 each  control to MEM→WB
- dest  out  REG_FILE_ADDR_LEN  destination to MEM→WB
- ALURes, memReadVal  out  WORD_LEN  ALU result and load data to MEM→WB
- freeze  out  1  hold IF/ID/EX and EX→MEM register
- mem_req, mem_we  out  1 each  memory request; write qualifier
- mem_addr, mem_wdata  out  WORD_LEN  memory address, write data
- mem_rdata  in  WORD_LEN  memory read data
- mem_ready  in  1  memory completes the current request this cycle
- mem_err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Access = MEM_R_EN_IN | MEM_W_EN_IN. If both are set, the access is a read (mem_we=0).
- IDLE, no access:
  - outputs are combinational pass-through of inputs; memReadVal=0
  - freeze=0, mem_req=0
- IDLE, access:
  - latch WB_EN_IN, MEM_R_EN_IN, read/write kind, destIn, ALUResIn, STValIn
  - freeze=1; bubble outputs (WB_EN=0, MEM_R_EN=0, dest=0, ALURes=0, memReadVal=0)
  - next state BUSY; wait counter cleared to 0
- BUSY:
  - mem_req=1; mem_we, mem_addr, mem_wdata driven from latches and stable for the whole state
  - freeze=1; bubble outputs
  - mem_ready=1: capture mem_rdata (reads only; writes capture 0) → DONE
  - else counter+1; when counter reaches MAX_WAIT → DONE, captured data=0, mem_err←1
  - mem_ready in the MAX_WAIT-th cycle wins over timeout
- DONE:
  - outputs = latched WB_EN, MEM_R_EN, dest, ALURes and captured memReadVal
  - freeze=0, mem_req=0
  - unconditionally → IDLE; the still-held instruction on the inputs is not re-triggered
- Counter width is $clog2(MAX_WAIT+1); it never wraps.
- mem_ready outside BUSY is ignored.
- mem_err is cleared only by rst.

## Timing
- Reset (rst=0, asynchronous), all registered state cleared:
  - state=IDLE, latches=0, counter=0, mem_err=0
  - mem_req=0, freeze=0; bubble outputs
- Reset released mid-access: returns to IDLE; no partial result is ever presented.
- Non-memory instruction: 0 added cycles.
- Memory instruction with ready after k BUSY cycles (1≤k≤MAX_WAIT):
  - freeze high for k+1 cycles
  - result valid in DONE, cycle k+1 after detection
  - sampled by MEM→WB at the end of DONE
- All state updates on rising clk; freeze, mem_req and the output mux are Moore outputs of state, except the IDLE pass-through/detect path.

## Test plan
- Reset: drive rst=0 mid-BUSY → mem_req=0, freeze=0, WB_EN=0, mem_err=0 immediately; after release, state IDLE.
- Pass-through: WB_EN_IN=1, destIn=5, ALUResIn=0x1234, no access → same cycle WB_EN=1, dest=5, ALURes=0x1234, memReadVal=0, freeze=0, mem_req=0.
- Load, 3-cycle latency: MEM_R_EN_IN=1, ALUResIn=0x40, destIn=3; ready on 3rd BUSY cycle with mem_rdata=0xDEADBEEF:
  - mem_addr=0x40 stable, freeze high 4 cycles
  - DONE shows WB_EN=1, MEM_R_EN=1, dest=3, memReadVal=0xDEADBEEF
  - next cycle IDLE, no second request
- Store: MEM_W_EN_IN=1, STValIn=0xA5, ready in 1st BUSY cycle → mem_we=1, mem_wdata=0xA5; DONE memReadVal=0; 2 freeze cycles.
- Timeout: MAX_WAIT=4, never ready → DONE after 4 BUSY cycles, memReadVal=0, mem_err=1 and stays set through later good accesses.
- Boundary: ready exactly in the 4th BUSY cycle (MAX_WAIT=4) → data captured, mem_err stays 0; MEM_R_EN_IN=MEM_W_EN_IN=1 → mem_we=0.
